// File: rtl/pwm_gen_multi_if.sv
// rtl/pwm_gen_multi_if.sv - control inputs and PWM outputs of pwm_gen_multi
interface pwm_gen_multi_if #(
    parameter int CHANNELS = 4,
    parameter int RES      = 4,
    parameter int DIV_W    = 6
);
    logic                    ena;
    logic [DIV_W-1:0]        divisor;
    logic [CHANNELS-1:0]     increase_duty;
    logic [CHANNELS-1:0]     decrease_duty;
    logic [CHANNELS-1:0]     pwm_out;
    logic                    period_start;
    logic [CHANNELS*RES-1:0] duty_q;

    modport master (
        output ena, divisor, increase_duty, decrease_duty,
        input  pwm_out, period_start, duty_q
    );

    modport slave (
        input  ena, divisor, increase_duty, decrease_duty,
        output pwm_out, period_start, duty_q
    );
endinterface

// File: rtl/pwm_gen_multi.sv
// rtl/pwm_gen_multi.sv - multi-channel PWM with shared prescaler, debounced duty buttons
// PWM_CENTER_ALIGN_EN selects up-down (centre-aligned) counting instead of a sawtooth.
module pwm_gen_multi #(
    parameter int CHANNELS  = 4,
    parameter int RES       = 4,
    parameter int PERIOD    = 10,
    parameter int DIV_W     = 6,
    parameter int DEB_TICKS = 2,
    parameter int DUTY_INIT = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    pwm_gen_multi_if.slave  bus
);
    localparam int               DEB_W    = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [RES-1:0]   PERIOD_V = RES'(PERIOD);
    localparam logic [RES-1:0]   LAST_V   = RES'(PERIOD - 1);
    localparam logic [RES-1:0]   INIT_V   = RES'(DUTY_INIT);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    // >= rather than == so a divisor lowered below div_cnt still ticks next cycle
    assign tick = bus.ena && (div_cnt >= bus.divisor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (bus.ena) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    logic [RES-1:0] cnt;
    logic [RES-1:0] cnt_next;
    logic           boundary;

`ifdef PWM_CENTER_ALIGN_EN
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
    dir_t dir, dir_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir <= DIR_UP;
        end else begin
            dir <= dir_next;
        end
    end

    // each end value is held for two ticks; the boundary is the turn at the bottom
    always_comb begin
        cnt_next = cnt;
        dir_next = dir;
        boundary = 1'b0;
        if (tick) begin
            unique case (dir)
                DIR_UP: begin
                    if (cnt == LAST_V) dir_next = DIR_DOWN;
                    else               cnt_next = cnt + 1'b1;
                end
                DIR_DOWN: begin
                    if (cnt == '0) begin
                        dir_next = DIR_UP;
                        boundary = 1'b1;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                default: dir_next = DIR_UP;
            endcase
        end
    end
`else
    always_comb begin
        cnt_next = cnt;
        boundary = 1'b0;
        if (tick) begin
            if (cnt == LAST_V) begin
                cnt_next = '0;
                boundary = 1'b1;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end
`endif

    logic period_start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt            <= cnt_next;
            period_start_q <= boundary;
        end
    end

    logic [DEB_W-1:0]    deb_cnt;
    logic                strobe;
    logic [CHANNELS-1:0] inc_s1, inc_s2, dec_s1, dec_s2;
    logic [CHANNELS-1:0] inc_req, dec_req;

    assign strobe = tick && (deb_cnt == DEB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            inc_s1  <= '0;
            inc_s2  <= '0;
            dec_s1  <= '0;
            dec_s2  <= '0;
        end else begin
            if (tick) begin
                deb_cnt <= strobe ? '0 : deb_cnt + 1'b1;
            end
            if (strobe) begin
                inc_s1 <= bus.increase_duty;
                inc_s2 <= inc_s1;
                dec_s1 <= bus.decrease_duty;
                dec_s2 <= dec_s1;
            end
        end
    end

    // rising edge across two samples: a held button yields a single request
    assign inc_req = {CHANNELS{strobe}} & inc_s1 & ~inc_s2;
    assign dec_req = {CHANNELS{strobe}} & dec_s1 & ~dec_s2;

    logic [CHANNELS-1:0][RES-1:0] duty_sh, duty_sh_next;
    logic [CHANNELS-1:0][RES-1:0] duty_act, duty_act_next;
    logic [CHANNELS-1:0]          pwm_q, pwm_next;

    always_comb begin
        duty_sh_next  = duty_sh;
        duty_act_next = duty_act;
        pwm_next      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (boundary) begin
                duty_act_next[i] = duty_sh[i];
            end
            if (inc_req[i] && !dec_req[i] && (duty_sh[i] != PERIOD_V)) begin
                duty_sh_next[i] = duty_sh[i] + 1'b1;
            end else if (dec_req[i] && !inc_req[i] && (duty_sh[i] != '0)) begin
                duty_sh_next[i] = duty_sh[i] - 1'b1;
            end
            // compare against next-state values so the output edge lines up with the counter
            pwm_next[i] = bus.ena && (cnt_next < duty_act_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh  <= {CHANNELS{INIT_V}};
            duty_act <= {CHANNELS{INIT_V}};
            pwm_q    <= '0;
        end else begin
            duty_sh  <= duty_sh_next;
            duty_act <= duty_act_next;
            pwm_q    <= pwm_next;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = period_start_q;
    assign bus.duty_q       = duty_act;

endmodule
